// File: rtl/pps_timing_pkg.sv
// ---------------------------------------------------------------------------
// pps_timing_pkg
// Shared timing constants for the PPS delay compensator family:
//   - timestamp field widths (seconds / sub-seconds in 2^-32 s units)
//   - per-channel FSM state encoding (IDLE, DELAY, PULSE)
//   - helper that applies a signed sub-second offset to a full timestamp
// ---------------------------------------------------------------------------
package pps_timing_pkg;

  localparam int TS_SEC_W    = 40;
  localparam int TS_SUBSEC_W = 32;
  localparam int TS_W        = TS_SEC_W + TS_SUBSEC_W;

  // Per-channel FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;

  // {sec, subsec} is treated as one 72-bit fixed-point number, so a signed
  // sub-second offset carries/borrows into seconds naturally. The sum wraps
  // mod 2^72, which makes seconds wrap mod 2^40 (0 - 1 -> 2^40-1).
  function automatic logic [TS_W-1:0] ts_apply_offset(
    input logic [TS_W-1:0]        ts,
    input logic [TS_SUBSEC_W-1:0] offset
  );
    return ts + {{TS_SEC_W{offset[TS_SUBSEC_W-1]}}, offset};
  endfunction

endpackage

// File: rtl/pps_delay_channel.sv
// ---------------------------------------------------------------------------
// pps_delay_channel
// One PPS channel: 3-flop synchroniser with rising-edge detect, a
// programmable cycle-exact delay, a fixed-width output pulse and a sticky
// overrun flag for edges that arrive while the channel is busy.
//
// Optional statistics (macro PPS_DELAY_COMP_MC_STATS_EN): saturating
// 16-bit counters of accepted and dropped edges.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   active        enable & ch_enable for this channel; low forces IDLE
//   pps_in        raw asynchronous PPS input
//   delay         requested delay in clocks (clamped to MAX_DELAY_CYCLES)
//   overrun_clr   single-cycle clear of overrun (and stats counters)
//   pps_out       registered delayed pulse
//   state         current FSM state (debug / busy derivation)
//   overrun       sticky dropped-edge flag
//   edge_count    accepted edges (stats build only)
//   drop_count    dropped edges  (stats build only)
// ---------------------------------------------------------------------------
module pps_delay_channel
  import pps_timing_pkg::*;
#(
  parameter int DELAY_W          = 24,
  parameter int MAX_DELAY_CYCLES = 100_000,
  parameter int PULSE_CYCLES     = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic               pps_in,
  input  logic [DELAY_W-1:0] delay,
  input  logic               overrun_clr,
  output logic               pps_out,
  output logic [1:0]         state,
  output logic               overrun
`ifdef PPS_DELAY_COMP_MC_STATS_EN
  , output logic [15:0]      edge_count
  , output logic [15:0]      drop_count
`endif
);

  localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [DELAY_W-1:0] MAX_D      = DELAY_W'(MAX_DELAY_CYCLES);
  localparam logic [PCNT_W-1:0]  PULSE_LOAD = PCNT_W'(PULSE_CYCLES);
  localparam logic [DELAY_W-1:0] DCNT_ONE   = DELAY_W'(1);
  localparam logic [PCNT_W-1:0]  PCNT_ONE   = PCNT_W'(1);

  logic               s1, s2, s3;
  logic               rise;
  logic               pend;
  logic [DELAY_W-1:0] d_clamped;
  logic [DELAY_W-1:0] dcnt;
  logic [PCNT_W-1:0]  pcnt;
  logic               last_pulse;
  logic               trigger;
  logic               accept;
  logic               drop;

  // Synchroniser keeps running regardless of enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pps_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign d_clamped  = (delay > MAX_D) ? MAX_D : delay;
  assign last_pulse = (state == ST_PULSE) && (pcnt == PCNT_ONE);
  // pend carries an edge seen in the final PULSE cycle into IDLE.
  assign trigger    = rise | pend;
  assign accept     = active && (state == ST_IDLE) && trigger;
  assign drop       = active && rise && (state != ST_IDLE) && !last_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pps_out <= 1'b0;
      pend    <= 1'b0;
      dcnt    <= '0;
      pcnt    <= '0;
    end else if (!active) begin
      state   <= ST_IDLE;
      pps_out <= 1'b0;
      pend    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pend <= 1'b0;
          if (trigger) begin
            if (d_clamped == '0) begin
              state   <= ST_PULSE;
              pps_out <= 1'b1;
              pcnt    <= PULSE_LOAD;
            end else begin
              state <= ST_DELAY;
              dcnt  <= d_clamped;
            end
          end
        end
        ST_DELAY: begin
          // Counter holds D on entry; PULSE starts on the D-th DELAY edge.
          if (dcnt == DCNT_ONE) begin
            state   <= ST_PULSE;
            pps_out <= 1'b1;
            pcnt    <= PULSE_LOAD;
          end else begin
            dcnt <= dcnt - DCNT_ONE;
          end
        end
        ST_PULSE: begin
          if (pcnt == PCNT_ONE) begin
            state   <= ST_IDLE;
            pps_out <= 1'b0;
            pend    <= rise;
          end else begin
            pcnt <= pcnt - PCNT_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pps_out <= 1'b0;
          pend    <= 1'b0;
        end
      endcase
    end
  end

  // A new drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= drop | (overrun & ~overrun_clr);
  end

`ifdef PPS_DELAY_COMP_MC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      drop_count <= '0;
    end else begin
      if (overrun_clr)                      edge_count <= {15'd0, accept};
      else if (accept && edge_count != '1)  edge_count <= edge_count + 16'd1;
      if (overrun_clr)                      drop_count <= {15'd0, drop};
      else if (drop && drop_count != '1)    drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/pps_delay_comp_mc.sv
// ---------------------------------------------------------------------------
// pps_delay_comp_mc
// Multi-channel PPS delay compensator. NUM_CH independent channels each
// delay their PPS edge by a programmable number of clocks and emit a
// PULSE_CYCLES-wide pulse. A shared 2-stage timestamp path adds a signed
// sub-second offset with carry/borrow into seconds.
//
// Optional feature macro: PPS_DELAY_COMP_MC_STATS_EN (adds edge_count and
// drop_count ports, 16 bits per channel).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            global channel enable (timestamp path ignores it)
//   ch_enable         per-channel enable
//   pps_in            raw asynchronous PPS inputs
//   delay_cycles      channel i delay at [i*DELAY_W +: DELAY_W]
//   overrun_clr       clear all overrun flags
//   pps_out           delayed PPS pulses
//   busy              channel in DELAY or PULSE
//   overrun           sticky dropped-edge flags
//   ts_sec_in, ts_subsec_in, ts_valid_in, ts_offset_subsec   timestamp in
//   ts_sec_out, ts_subsec_out, ts_valid_out                  timestamp out
//
// Timestamp strobe semantics: valid-only, no backpressure. Every cycle with
// ts_valid_in high is a transfer; ts_valid_out pulses exactly 2 cycles
// later with the compensated value, so back-to-back strobes are fine.
// ---------------------------------------------------------------------------
module pps_delay_comp_mc
  import pps_timing_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int DELAY_W          = 24,
  parameter int MAX_DELAY_CYCLES = 100_000,
  parameter int PULSE_CYCLES     = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         pps_in,
  input  logic [NUM_CH*DELAY_W-1:0] delay_cycles,
  input  logic                      overrun_clr,
  output logic [NUM_CH-1:0]         pps_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         overrun,
  input  logic [TS_SEC_W-1:0]       ts_sec_in,
  input  logic [TS_SUBSEC_W-1:0]    ts_subsec_in,
  input  logic                      ts_valid_in,
  input  logic [TS_SUBSEC_W-1:0]    ts_offset_subsec,
  output logic [TS_SEC_W-1:0]       ts_sec_out,
  output logic [TS_SUBSEC_W-1:0]    ts_subsec_out,
  output logic                      ts_valid_out
`ifdef PPS_DELAY_COMP_MC_STATS_EN
  , output logic [NUM_CH*16-1:0]    edge_count
  , output logic [NUM_CH*16-1:0]    drop_count
`endif
);

  logic [1:0] ch_state [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pps_delay_channel #(
      .DELAY_W          (DELAY_W),
      .MAX_DELAY_CYCLES (MAX_DELAY_CYCLES),
      .PULSE_CYCLES     (PULSE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (enable & ch_enable[g]),
      .pps_in      (pps_in[g]),
      .delay       (delay_cycles[g*DELAY_W +: DELAY_W]),
      .overrun_clr (overrun_clr),
      .pps_out     (pps_out[g]),
      .state       (ch_state[g]),
      .overrun     (overrun[g])
`ifdef PPS_DELAY_COMP_MC_STATS_EN
      , .edge_count (edge_count[g*16 +: 16])
      , .drop_count (drop_count[g*16 +: 16])
`endif
    );
    assign busy[g] = (ch_state[g] != ST_IDLE);
  end

  // Timestamp pipeline: stage 1 holds the sum, stage 2 drives the outputs.
  logic [TS_W-1:0] s1_sum;
  logic            s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum        <= '0;
      s1_valid      <= 1'b0;
      ts_sec_out    <= '0;
      ts_subsec_out <= '0;
      ts_valid_out  <= 1'b0;
    end else begin
      s1_valid     <= ts_valid_in;
      ts_valid_out <= s1_valid;
      if (ts_valid_in)
        s1_sum <= ts_apply_offset({ts_sec_in, ts_subsec_in}, ts_offset_subsec);
      if (s1_valid)
        {ts_sec_out, ts_subsec_out} <= s1_sum;
    end
  end

endmodule

// File: tb/tb_pps_delay_comp_mc.sv
// ---------------------------------------------------------------------------
// tb_pps_delay_comp_mc
// Directed bench for pps_delay_comp_mc. The clamp limit is shortened to
// 300 cycles so the clamped-delay case stays short; all other parameters
// are the design defaults. Inputs change 1 time unit after a rising edge,
// outputs are sampled at the same point, so "edge k" below means the
// state just after rising edge number k.
// ---------------------------------------------------------------------------
module tb_pps_delay_comp_mc;

  localparam int NUM_CH   = 4;
  localparam int DELAY_W  = 24;
  localparam int MAX_D    = 300;
  localparam int PULSE    = 1000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                      enable;
  logic [NUM_CH-1:0]         ch_enable;
  logic [NUM_CH-1:0]         pps_in;
  logic [NUM_CH*DELAY_W-1:0] delay_cycles;
  logic                      overrun_clr;
  logic [NUM_CH-1:0]         pps_out;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         overrun;
  logic [39:0]               ts_sec_in;
  logic [31:0]               ts_subsec_in;
  logic                      ts_valid_in;
  logic [31:0]               ts_offset_subsec;
  logic [39:0]               ts_sec_out;
  logic [31:0]               ts_subsec_out;
  logic                      ts_valid_out;
`ifdef PPS_DELAY_COMP_MC_STATS_EN
  logic [NUM_CH*16-1:0]      edge_count;
  logic [NUM_CH*16-1:0]      drop_count;
`endif

  pps_delay_comp_mc #(
    .NUM_CH           (NUM_CH),
    .DELAY_W          (DELAY_W),
    .MAX_DELAY_CYCLES (MAX_D),
    .PULSE_CYCLES     (PULSE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .ch_enable        (ch_enable),
    .pps_in           (pps_in),
    .delay_cycles     (delay_cycles),
    .overrun_clr      (overrun_clr),
    .pps_out          (pps_out),
    .busy             (busy),
    .overrun          (overrun),
    .ts_sec_in        (ts_sec_in),
    .ts_subsec_in     (ts_subsec_in),
    .ts_valid_in      (ts_valid_in),
    .ts_offset_subsec (ts_offset_subsec),
    .ts_sec_out       (ts_sec_out),
    .ts_subsec_out    (ts_subsec_out),
    .ts_valid_out     (ts_valid_out)
`ifdef PPS_DELAY_COMP_MC_STATS_EN
    , .edge_count     (edge_count)
    , .drop_count     (drop_count)
`endif
  );

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // One-cycle high on pps_in[ch]; k returns the edge that sampled it.
  task automatic pulse_in(input int ch, output int k);
    pps_in[ch] = 1'b1;
    tick();
    k = cyc;
    pps_in[ch] = 1'b0;
  endtask

  task automatic set_delay(input int ch, input logic [DELAY_W-1:0] val);
    delay_cycles[ch*DELAY_W +: DELAY_W] = val;
  endtask

  task automatic drive_ts(input logic [39:0] sec, input logic [31:0] sub,
                          input logic [31:0] off, input logic vld);
    ts_sec_in        = sec;
    ts_subsec_in     = sub;
    ts_offset_subsec = off;
    ts_valid_in      = vld;
  endtask

  int k, k2;

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    ch_enable    = '1;
    pps_in       = '0;
    delay_cycles = '0;
    overrun_clr  = 1'b0;
    drive_ts('0, '0, '0, 1'b0);
    repeat (3) tick();

    // Reset state
    check("rst_pps_out", pps_out, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ts_valid", ts_valid_out, 0);
    check("rst_ts_sec", ts_sec_out, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // ch0, D=50: high at edges k+52 .. k+1051
    set_delay(0, 24'd50);
    pulse_in(0, k);
    wait_until(k + 51);
    check("ch0_pre_rise", pps_out[0], 0);
    check("ch0_busy_delay", busy[0], 1);
    wait_until(k + 52);
    check("ch0_rise", pps_out[0], 1);
    wait_until(k + 1051);
    check("ch0_last_high", pps_out[0], 1);
    wait_until(k + 1052);
    check("ch0_fall", pps_out[0], 0);
    check("ch0_busy_drop", busy[0], 0);
    check("ch0_no_overrun", overrun[0], 0);

    // ch1, D=0: rises at k+2, 1000 cycles wide
    set_delay(1, 24'd0);
    pulse_in(1, k);
    wait_until(k + 1);
    check("ch1_pre_rise", pps_out[1], 0);
    wait_until(k + 2);
    check("ch1_rise", pps_out[1], 1);
    wait_until(k + 1001);
    check("ch1_last_high", pps_out[1], 1);
    wait_until(k + 1002);
    check("ch1_fall", pps_out[1], 0);

    // ch2, D=2000 clamped to 300; later delay write must not matter
    set_delay(2, 24'd2000);
    pulse_in(2, k);
    wait_until(k + 5);
    set_delay(2, 24'd10);
    wait_until(k + 301);
    check("ch2_clamp_pre", pps_out[2], 0);
    wait_until(k + 302);
    check("ch2_clamp_rise", pps_out[2], 1);
    wait_until(k + 1302);
    check("ch2_clamp_fall", pps_out[2], 0);

    // ch0 overrun: second edge mid-DELAY is dropped
    repeat (5) tick();
    pulse_in(0, k);
    wait_until(k + 18);
    pulse_in(0, k2);   // k2 = k+19, edge reaches the FSM at k+21
    wait_until(k + 20);
    check("ovr_before", overrun[0], 0);
    wait_until(k + 21);
    check("ovr_set", overrun[0], 1);
    wait_until(k + 52);
    check("ovr_rise", pps_out[0], 1);
    wait_until(k + 1052);
    check("ovr_fall", pps_out[0], 0);
    wait_until(k + 1110);
    check("ovr_single_pulse", pps_out[0], 0);
    check("ovr_idle", busy[0], 0);
    check("ovr_sticky", overrun[0], 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun[0], 0);

    // ch0 edge in final PULSE cycle: accepted, second pulse, no overrun
    repeat (5) tick();
    pulse_in(0, k);
    wait_until(k + 1049);
    pulse_in(0, k2);   // k2 = k+1050, edge seen during final PULSE cycle
    wait_until(k + 1052);
    check("last_fall", pps_out[0], 0);
    check("last_no_ovr", overrun[0], 0);
    wait_until(k + 1053);
    check("last_busy_again", busy[0], 1);
    wait_until(k + 1102);
    check("last_pre_rise2", pps_out[0], 0);
    wait_until(k + 1103);
    check("last_rise2", pps_out[0], 1);
    wait_until(k + 2103);
    check("last_fall2", pps_out[0], 0);
    check("last_ovr_final", overrun[0], 0);

    // Timestamp path, with enable low to show it is independent
    enable = 1'b0;
    drive_ts(40'd5, 32'hFFFF_FF00, 32'h0000_0200, 1'b1);
    tick();
    check("ts_lat1_valid", ts_valid_out, 0);
    drive_ts(40'd5, 32'h0000_0010, 32'hFFFF_FFE0, 1'b1);   // -0x20
    tick();
    check("ts_carry_valid", ts_valid_out, 1);
    check("ts_carry_sec", ts_sec_out, 64'd6);
    check("ts_carry_sub", ts_subsec_out, 64'h100);
    drive_ts(40'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);             // -1
    tick();
    check("ts_borrow_valid", ts_valid_out, 1);
    check("ts_borrow_sec", ts_sec_out, 64'd4);
    check("ts_borrow_sub", ts_subsec_out, 64'hFFFF_FFF0);
    drive_ts(40'd0, 32'd0, 32'd0, 1'b0);
    tick();
    check("ts_wrap_sec", ts_sec_out, 64'hFF_FFFF_FFFF);
    check("ts_wrap_sub", ts_subsec_out, 64'hFFFF_FFFF);
    tick();
    check("ts_valid_end", ts_valid_out, 0);
    check("ts_hold_sec", ts_sec_out, 64'hFF_FFFF_FFFF);
    enable = 1'b1;

    // ch3: ch_enable dropped mid-DELAY
    set_delay(3, 24'd100);
    pulse_in(3, k);
    wait_until(k + 20);
    check("ch3_busy_delay", busy[3], 1);
    ch_enable[3] = 1'b0;
    tick();
    check("ch3_dis_busy", busy[3], 0);
    check("ch3_dis_out", pps_out[3], 0);
    ch_enable[3] = 1'b1;
    wait_until(k + 150);
    check("ch3_no_pulse", pps_out[3], 0);

    // Reset asserted mid-PULSE on ch0 clears output immediately
    set_delay(0, 24'd0);
    pulse_in(0, k);
    wait_until(k + 10);
    check("rstmid_high", pps_out[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_out", pps_out[0], 0);
    check("rstmid_busy", busy[0], 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
